// File: rtl/alu_pkg.sv
// Shared constants for the ALU result collector: default sizes and the source codes
// tagged on each queued result.
package alu_pkg;

   localparam int ALU_WIDTH_DEF = 16;
   localparam int ALU_DEPTH_DEF = 4;

   typedef enum logic [1:0] {
      SRC_ARITH = 2'd0,
      SRC_LOGIC = 2'd1,
      SRC_CMP   = 2'd2,
      SRC_SHIFT = 2'd3
   } src_e;

   function automatic logic [2:0] flag_count(input logic [3:0] f);
      return {2'b00, f[0]} + {2'b00, f[1]} + {2'b00, f[2]} + {2'b00, f[3]};
   endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Result queue with registered storage. The pointers carry one extra bit so that
// full and empty can be told apart.
module alu_result_fifo #(
   parameter int DW    = 35,
   parameter int DEPTH = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata,
   output logic          full,
   output logic          empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [DW-1:0] mem_q [DEPTH];
   logic          push_ok_s, pop_ok_s;

   assign empty     = (wptr_q == rptr_q);
   assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign push_ok_s = push && (!full || pop);
   assign pop_ok_s  = pop && !empty;
   assign rdata     = mem_q[rptr_q[AW-1:0]];

   // next-state pointer arithmetic
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push_ok_s) begin
         wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
         wptr_d = wptr_q;
      end
      if (pop_ok_s) begin
         rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
         rptr_d = rptr_q;
      end
   end

   // pointer registers
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // storage is left unreset; only the pointers define what is valid
   always_ff @(posedge CLK) begin
      if (push_ok_s) begin
         mem_q[wptr_q[AW-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/alu_result_collector.sv
// Collects single-unit ALU results into an in-order FIFO. Optional drop counter is
// enabled by defining ALU_COLLECT_DROP_CNT_EN; otherwise DROP_CNT reads 0.
module alu_result_collector
   import alu_pkg::*;
#(
   parameter int width = ALU_WIDTH_DEF,
   parameter int DEPTH = ALU_DEPTH_DEF
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [2*width-1:0] Arith_OUT,
   input  logic               Carry_OUT,
   input  logic [width-1:0]   Logic_OUT,
   input  logic [width-1:0]   CMP_OUT,
   input  logic [width:0]     SHIFT_OUT,
   input  logic               Arith_Flag,
   input  logic               Logic_Flag,
   input  logic               CMP_Flag,
   input  logic               SHIFT_Flag,
   output logic [2*width-1:0] ALU_OUT,
   output logic [1:0]         OUT_SRC,
   output logic               OUT_CARRY,
   output logic               OUT_VALID,
   input  logic               OUT_READY,
   output logic               MULTI_ERR,
   output logic [7:0]         DROP_CNT
);

   localparam int DW = 2*width + 3;

   logic [3:0]    flags_s;
   logic          single_s, multi_s, push_s, pop_s, drop_s;
   logic          fifo_full_s, fifo_empty_s;
   logic [DW-1:0] entry_s, head_s;
   logic          multi_err_q, multi_err_d;

   assign flags_s  = {SHIFT_Flag, CMP_Flag, Logic_Flag, Arith_Flag};
   assign single_s = (flag_count(flags_s) == 3'd1);
   assign multi_s  = (flag_count(flags_s) >  3'd1);
   assign pop_s    = OUT_VALID && OUT_READY;
   assign push_s   = single_s && (!fifo_full_s || pop_s);
   assign drop_s   = single_s && !push_s;

   // entry layout is {word, src, carry}
   always_comb begin
      entry_s = '0;
      case (flags_s)
         4'b0001: entry_s = {Arith_OUT, SRC_ARITH, Carry_OUT};
         4'b0010: entry_s = {{width{1'b0}}, Logic_OUT, SRC_LOGIC, 1'b0};
         4'b0100: entry_s = {{width{1'b0}}, CMP_OUT, SRC_CMP, 1'b0};
         4'b1000: entry_s = {{(width-1){1'b0}}, SHIFT_OUT, SRC_SHIFT, 1'b0};
         default: entry_s = '0;
      endcase
   end

   alu_result_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .push  (push_s),
      .pop   (pop_s),
      .wdata (entry_s),
      .rdata (head_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   assign OUT_VALID = !fifo_empty_s;
   assign ALU_OUT   = fifo_empty_s ? '0   : head_s[DW-1:3];
   assign OUT_SRC   = fifo_empty_s ? 2'b00 : head_s[2:1];
   assign OUT_CARRY = fifo_empty_s ? 1'b0 : head_s[0];

   // sticky collision flag
   always_comb begin
      if (multi_s) begin
         multi_err_d = 1'b1;
      end else begin
         multi_err_d = multi_err_q;
      end
   end

   // collision flag register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         multi_err_q <= 1'b0;
      end else begin
         multi_err_q <= multi_err_d;
      end
   end

   assign MULTI_ERR = multi_err_q;

`ifdef ALU_COLLECT_DROP_CNT_EN
   logic [7:0] drop_cnt_q, drop_cnt_d;

   // saturating drop counter
   always_comb begin
      if (drop_s && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
   end

   // drop counter register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         drop_cnt_q <= 8'h00;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign DROP_CNT = drop_cnt_q;
`else
   logic drop_unused_s;
   assign drop_unused_s = drop_s;
   assign DROP_CNT      = 8'h00;
`endif

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed self-checking bench for alu_result_collector (width=16, DEPTH=4).
module tb_alu_result_collector;

   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] Arith_OUT;
   logic        Carry_OUT;
   logic [15:0] Logic_OUT, CMP_OUT;
   logic [16:0] SHIFT_OUT;
   logic        Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag;
   logic [31:0] ALU_OUT;
   logic [1:0]  OUT_SRC;
   logic        OUT_CARRY, OUT_VALID, OUT_READY, MULTI_ERR;
   logic [7:0]  DROP_CNT;

   int total = 0;
   int bad   = 0;

`ifdef ALU_COLLECT_DROP_CNT_EN
   localparam logic [7:0] EXP_DROP = 8'd1;
`else
   localparam logic [7:0] EXP_DROP = 8'd0;
`endif

   alu_result_collector #(.width(16), .DEPTH(4)) dut (
      .CLK(CLK), .RST(RST),
      .Arith_OUT(Arith_OUT), .Carry_OUT(Carry_OUT),
      .Logic_OUT(Logic_OUT), .CMP_OUT(CMP_OUT), .SHIFT_OUT(SHIFT_OUT),
      .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag),
      .CMP_Flag(CMP_Flag), .SHIFT_Flag(SHIFT_Flag),
      .ALU_OUT(ALU_OUT), .OUT_SRC(OUT_SRC), .OUT_CARRY(OUT_CARRY),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
      .MULTI_ERR(MULTI_ERR), .DROP_CNT(DROP_CNT)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [31:0] drain_exp [4];
      drain_exp[0] = 32'd2; drain_exp[1] = 32'd3; drain_exp[2] = 32'd4; drain_exp[3] = 32'd6;

      RST = 1'b0; OUT_READY = 1'b0;
      Arith_OUT = 32'h0; Carry_OUT = 1'b0; Logic_OUT = 16'h0; CMP_OUT = 16'h0; SHIFT_OUT = 17'h0;
      Arith_Flag = 1'b0; Logic_Flag = 1'b0; CMP_Flag = 1'b0; SHIFT_Flag = 1'b0;
      #2;
      chk("rst_valid", OUT_VALID, 1'b0);
      chk("rst_out",   ALU_OUT, 32'h0);
      chk("rst_src",   OUT_SRC, 2'd0);
      chk("rst_carry", OUT_CARRY, 1'b0);
      chk("rst_multi", MULTI_ERR, 1'b0);
      chk("rst_drop",  DROP_CNT, 8'd0);
      tick();
      RST = 1'b1;

      // NOP: nothing captured even with data and carry present
      Carry_OUT = 1'b1; Arith_OUT = 32'h12345678; OUT_READY = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("nop_valid", OUT_VALID, 1'b0);
      end
      chk("nop_out",   ALU_OUT, 32'h0);
      chk("nop_src",   OUT_SRC, 2'd0);
      chk("nop_carry", OUT_CARRY, 1'b0);
      chk("nop_multi", MULTI_ERR, 1'b0);
      chk("nop_drop",  DROP_CNT, 8'd0);

      // Arithmetic push, then popped the following edge
      Arith_Flag = 1'b1; Arith_OUT = -32'sd17600; Carry_OUT = 1'b1;
      tick();
      Arith_Flag = 1'b0;
      chk("ar_valid", OUT_VALID, 1'b1);
      chk("ar_out",   ALU_OUT, 32'hFFFFBB40);
      chk("ar_src",   OUT_SRC, 2'd0);
      chk("ar_carry", OUT_CARRY, 1'b1);
      tick();
      chk("ar_popped", OUT_VALID, 1'b0);
      chk("ar_popped_out", ALU_OUT, 32'h0);

      // Logic then Shift with consumer stalled; carry input left high
      OUT_READY = 1'b0;
      Logic_Flag = 1'b1; Logic_OUT = 16'h0188;
      tick();
      Logic_Flag = 1'b0; SHIFT_Flag = 1'b1; SHIFT_OUT = 17'h1C350;
      tick();
      SHIFT_Flag = 1'b0;
      chk("lg_out",   ALU_OUT, 32'h00000188);
      chk("lg_src",   OUT_SRC, 2'd1);
      chk("lg_carry", OUT_CARRY, 1'b0);
      OUT_READY = 1'b1;
      tick();
      OUT_READY = 1'b0;
      chk("sh_valid", OUT_VALID, 1'b1);
      chk("sh_out",   ALU_OUT, 32'h0001C350);
      chk("sh_src",   OUT_SRC, 2'd3);
      chk("sh_carry", OUT_CARRY, 1'b0);
      OUT_READY = 1'b1;
      tick();
      OUT_READY = 1'b0;
      chk("sh_popped", OUT_VALID, 1'b0);

      // Overflow: five pushes into a depth-4 queue
      for (int i = 1; i <= 5; i++) begin
         CMP_Flag = 1'b1; CMP_OUT = 16'(i);
         tick();
      end
      chk("ov_valid", OUT_VALID, 1'b1);
      chk("ov_head",  ALU_OUT, 32'd1);
      chk("ov_src",   OUT_SRC, 2'd2);
      chk("ov_drop",  DROP_CNT, EXP_DROP);
      CMP_OUT = 16'd6; OUT_READY = 1'b1;
      tick();
      CMP_Flag = 1'b0; OUT_READY = 1'b0;
      chk("fullpp_drop", DROP_CNT, EXP_DROP);
      for (int i = 0; i < 4; i++) begin
         chk("drain_valid", OUT_VALID, 1'b1);
         chk("drain_out", ALU_OUT, drain_exp[i]);
         OUT_READY = 1'b1;
         tick();
         OUT_READY = 1'b0;
      end
      chk("drain_empty", OUT_VALID, 1'b0);
      chk("pre_multi", MULTI_ERR, 1'b0);

      // Collision: two flags together push nothing and latch the error
      Arith_Flag = 1'b1; Arith_OUT = 32'h00000042; Carry_OUT = 1'b0;
      tick();
      CMP_Flag = 1'b1; CMP_OUT = 16'h0099;
      tick();
      Arith_Flag = 1'b0; CMP_Flag = 1'b0;
      chk("mu_valid", OUT_VALID, 1'b1);
      chk("mu_head",  ALU_OUT, 32'h00000042);
      chk("mu_err",   MULTI_ERR, 1'b1);
      OUT_READY = 1'b1;
      tick();
      OUT_READY = 1'b0;
      chk("mu_nopush", OUT_VALID, 1'b0);
      chk("mu_sticky", MULTI_ERR, 1'b1);

      // Reset mid-operation with three entries queued
      for (int i = 1; i <= 3; i++) begin
         Logic_Flag = 1'b1; Logic_OUT = 16'(i * 17);
         tick();
      end
      Logic_Flag = 1'b0;
      chk("q3_valid", OUT_VALID, 1'b1);
      chk("q3_head",  ALU_OUT, 32'd17);
      #2;
      RST = 1'b0;
      #1;
      chk("mr_valid", OUT_VALID, 1'b0);
      chk("mr_out",   ALU_OUT, 32'h0);
      chk("mr_multi", MULTI_ERR, 1'b0);
      chk("mr_drop",  DROP_CNT, 8'd0);
      Logic_Flag = 1'b1; Logic_OUT = 16'h0099;
      tick();
      chk("mr_nocapture", OUT_VALID, 1'b0);
      RST = 1'b1; Logic_OUT = 16'h0077;
      tick();
      Logic_Flag = 1'b0;
      chk("pr_valid", OUT_VALID, 1'b1);
      chk("pr_out",   ALU_OUT, 32'h00000077);
      chk("pr_src",   OUT_SRC, 2'd1);
      OUT_READY = 1'b1;
      tick();
      OUT_READY = 1'b0;
      chk("pr_sole", OUT_VALID, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
